// File: rtl/pwm_pkg.sv
// Shared register map and field positions for the PWM bank.
package pwm_pkg;

   // Only the low address bits take part in decoding
   localparam int unsigned AddrDecodeW = 10;

   // Channel registers are laid out on a 4-byte stride starting at offset 0
   localparam int unsigned ChStride    = 4;

   // Global control register
   localparam logic [AddrDecodeW-1:0] CtrlOffset = 10'h200;
   localparam int unsigned CtrlEnBit   = 0;
   localparam int unsigned CtrlPsLsb   = 8;
   localparam int unsigned PsWidth     = 8;

   // Period field position inside a channel register
   localparam int unsigned ChPeriodLsb = 16;

   // Merge two byte lanes of write data into a 16-bit field under byte enables
   function automatic logic [15:0] merge_bytes(input logic [15:0] old_val,
                                               input logic [1:0]  be,
                                               input logic [15:0] wdata);
      logic [15:0] res;
      res = old_val;
      if (be[0]) begin
         res[7:0] = wdata[7:0];
      end else begin
         res[7:0] = old_val[7:0];
      end
      if (be[1]) begin
         res[15:8] = wdata[15:8];
      end else begin
         res[15:8] = old_val[15:8];
      end
      return res;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending (shadow) and active duty/period, tick counter and compare.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int unsigned CtrWidth = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                enable_i,
   input  logic                tick_i,
   input  logic                wr_i,
   input  logic [3:0]          be_i,
   input  logic [31:0]         wdata_i,
   output logic [CtrWidth-1:0] pend_duty_o,
   output logic [CtrWidth-1:0] pend_period_o,
   output logic                pwm_o
);

   logic [CtrWidth-1:0] pend_duty_q, pend_duty_d;
   logic [CtrWidth-1:0] pend_period_q, pend_period_d;
   logic [CtrWidth-1:0] act_duty_q, act_duty_d;
   logic [CtrWidth-1:0] act_period_q, act_period_d;
   logic [CtrWidth-1:0] cnt_q, cnt_d;
   logic [15:0]         duty_ext, period_ext;
   logic [15:0]         duty_merge, period_merge;
   logic                idle, wrap;
   logic                unused_merge;

   // Widen the pending fields to the 16-bit lane layout seen on the bus
   always_comb begin
      duty_ext                 = '0;
      period_ext               = '0;
      duty_ext[CtrWidth-1:0]   = pend_duty_q;
      period_ext[CtrWidth-1:0] = pend_period_q;
   end

   assign duty_merge   = merge_bytes(duty_ext, be_i[1:0], wdata_i[15:0]);
   assign period_merge = merge_bytes(period_ext, be_i[3:2], wdata_i[31:16]);
   // Bits above CtrWidth are truncated away
   assign unused_merge = ^{duty_merge, period_merge};

   // Load byte-enabled writes into the pending registers
   always_comb begin
      if (wr_i) begin
         pend_duty_d   = duty_merge[CtrWidth-1:0];
         pend_period_d = period_merge[CtrWidth-1:0];
      end else begin
         pend_duty_d   = pend_duty_q;
         pend_period_d = pend_period_q;
      end
   end

   assign idle = ~enable_i | (act_period_q == '0);
   assign wrap = tick_i & (cnt_q == act_period_q);

   // Counter advance and glitch-free shadow copy at wrap (old pending wins on a same-cycle write)
   always_comb begin
      cnt_d        = cnt_q;
      act_duty_d   = act_duty_q;
      act_period_d = act_period_q;
      if (idle) begin
         cnt_d        = '0;
         act_duty_d   = pend_duty_q;
         act_period_d = pend_period_q;
      end else if (wrap) begin
         cnt_d        = '0;
         act_duty_d   = pend_duty_q;
         act_period_d = pend_period_q;
      end else if (tick_i) begin
         cnt_d = cnt_q + CtrWidth'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Channel state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_duty_q   <= '0;
         pend_period_q <= '0;
         act_duty_q    <= '0;
         act_period_q  <= '0;
         cnt_q         <= '0;
      end else begin
         pend_duty_q   <= pend_duty_d;
         pend_period_q <= pend_period_d;
         act_duty_q    <= act_duty_d;
         act_period_q  <= act_period_d;
         cnt_q         <= cnt_d;
      end
   end

   assign pend_duty_o   = pend_duty_q;
   assign pend_period_o = pend_period_q;
   assign pwm_o         = enable_i & (act_period_q != '0) & (cnt_q < act_duty_q);

endmodule

// File: rtl/pwm_bank.sv
// PWM bank: register decode, global prescaler, readback and NumChannels channels.
module pwm_bank
   import pwm_pkg::*;
#(
   parameter int unsigned NumChannels = 12,
   parameter int unsigned CtrWidth    = 8,
   parameter int unsigned BusWidth    = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   device_req_i,
   input  logic [BusWidth-1:0]    device_addr_i,
   input  logic                   device_we_i,
   input  logic [3:0]             device_be_i,
   input  logic [BusWidth-1:0]    device_wdata_i,
   output logic                   device_rvalid_o,
   output logic [BusWidth-1:0]    device_rdata_o,
   output logic [NumChannels-1:0] pwm_o
);

   logic [AddrDecodeW-1:0] addr_off, word_idx;
   logic                   ctrl_hit, ctrl_wr, ps_restart, tick;
   logic                   enable_q, enable_d;
   logic [PsWidth-1:0]     prescale_q, prescale_d;
   logic [PsWidth-1:0]     pscnt_q, pscnt_d;
   logic [NumChannels-1:0] ch_wr;
   logic [NumChannels-1:0][CtrWidth-1:0] pend_duty, pend_period;
   logic [31:0]            rd_val;
   logic                   rvalid_q, rvalid_d;
   logic [BusWidth-1:0]    rdata_q, rdata_d;
   logic                   unused_addr;

   assign addr_off    = device_addr_i[AddrDecodeW-1:0];
   assign word_idx    = addr_off / 10'(ChStride);
   assign ctrl_hit    = (word_idx == (CtrlOffset / 10'(ChStride)));
   assign ctrl_wr     = device_req_i & device_we_i & ctrl_hit;
   assign unused_addr = ^device_addr_i[BusWidth-1:AddrDecodeW];

   // Byte-enabled CTRL update; any prescale write restarts the prescaler
   always_comb begin
      enable_d   = enable_q;
      prescale_d = prescale_q;
      ps_restart = 1'b0;
      if (ctrl_wr) begin
         if (device_be_i[0]) begin
            enable_d = device_wdata_i[CtrlEnBit];
         end else begin
            enable_d = enable_q;
         end
         if (device_be_i[1]) begin
            prescale_d = device_wdata_i[CtrlPsLsb +: PsWidth];
            ps_restart = 1'b1;
         end else begin
            prescale_d = prescale_q;
         end
      end else begin
         enable_d   = enable_q;
         prescale_d = prescale_q;
      end
   end

   assign tick = enable_q & (pscnt_q == prescale_q);

   // Prescaler counts 0..prescale while enabled, held at 0 otherwise
   always_comb begin
      if (!enable_q || ps_restart) begin
         pscnt_d = '0;
      end else if (tick) begin
         pscnt_d = '0;
      end else begin
         pscnt_d = pscnt_q + PsWidth'(1);
      end
   end

   // Per-channel write strobes; indices at or beyond NumChannels never match
   always_comb begin
      ch_wr = '0;
      for (int i = 0; i < int'(NumChannels); i++) begin
         if (device_req_i && device_we_i && (word_idx == 10'(i))) begin
            ch_wr[i] = 1'b1;
         end else begin
            ch_wr[i] = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < int'(NumChannels); g++) begin : g_ch
      pwm_channel #(
         .CtrWidth (CtrWidth)
      ) u_ch (
         .clk_i         (clk_i),
         .rst_ni        (rst_ni),
         .enable_i      (enable_q),
         .tick_i        (tick),
         .wr_i          (ch_wr[g]),
         .be_i          (device_be_i),
         .wdata_i       (device_wdata_i[31:0]),
         .pend_duty_o   (pend_duty[g]),
         .pend_period_o (pend_period[g]),
         .pwm_o         (pwm_o[g])
      );
   end

   // Readback mux over pending channel values and CTRL, zero for unmapped offsets
   always_comb begin
      rd_val = '0;
      if (ctrl_hit) begin
         rd_val[CtrlEnBit]            = enable_q;
         rd_val[CtrlPsLsb +: PsWidth] = prescale_q;
      end else begin
         for (int i = 0; i < int'(NumChannels); i++) begin
            if (word_idx == 10'(i)) begin
               rd_val[CtrWidth-1:0]             = pend_duty[i];
               rd_val[ChPeriodLsb +: CtrWidth]  = pend_period[i];
            end else begin
               rd_val = rd_val;
            end
         end
      end
   end

   // One response per request; data only for reads
   always_comb begin
      rvalid_d = device_req_i;
      rdata_d  = '0;
      if (device_req_i && !device_we_i) begin
         rdata_d[31:0] = rd_val;
      end else begin
         rdata_d = '0;
      end
   end

   // Control, prescaler and bus response registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         enable_q   <= 1'b0;
         prescale_q <= '0;
         pscnt_q    <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         enable_q   <= enable_d;
         prescale_q <= prescale_d;
         pscnt_q    <= pscnt_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

   assign device_rvalid_o = rvalid_q;
   assign device_rdata_o  = rdata_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Randomized scoreboard bench for pwm_bank with a tick-level behavioural model.
module tb_pwm_bank;

   localparam int NCH = 12;
   localparam int W   = 8;
   localparam int BW  = 32;
   localparam logic [31:0] DMASK      = (32'd1 << W) - 32'd1;
   localparam logic [31:0] FIELD_CH   = DMASK | (DMASK << 16);
   localparam logic [31:0] FIELD_CTRL = 32'h0000FF01;

   logic            clk;
   logic            rst_ni;
   logic            req;
   logic [BW-1:0]   addr;
   logic            we;
   logic [3:0]      be;
   logic [BW-1:0]   wdata;
   logic            rvalid;
   logic [BW-1:0]   rdata;
   logic [NCH-1:0]  pwm_o;

   pwm_bank #(.NumChannels(NCH), .CtrWidth(W), .BusWidth(BW)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .device_req_i   (req),
      .device_addr_i  (addr),
      .device_we_i    (we),
      .device_be_i    (be),
      .device_wdata_i (wdata),
      .device_rvalid_o(rvalid),
      .device_rdata_o (rdata),
      .pwm_o          (pwm_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned issue;
      logic [31:0] exp;
      logic [31:0] addr;
   } resp_t;
   resp_t rq[$];

   // Reference state: register images, active fields, ticks elapsed in current PWM cycle
   logic [31:0] m_ch [NCH];
   logic [31:0] m_ctrl;
   int unsigned m_psc;
   int unsigned m_act_d [NCH];
   int unsigned m_act_p [NCH];
   int unsigned m_phase [NCH];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] bytemask(input logic [3:0] b);
      logic [31:0] m;
      m = 32'h0;
      for (int k = 0; k < 4; k++) if (b[k]) m = m | (32'hFF << (8 * k));
      return m;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int unsigned idx;
      idx = int'(a[9:2]);
      if (idx < NCH) return m_ch[idx];
      else if (idx == 128) return m_ctrl;
      else return 32'h0;
   endfunction

   function automatic logic [NCH-1:0] model_pwm();
      logic [NCH-1:0] v;
      for (int i = 0; i < NCH; i++)
         v[i] = m_ctrl[0] && (m_act_p[i] != 0) && (m_phase[i] < m_act_d[i]);
      return v;
   endfunction

   task automatic model_reset();
      m_ctrl = 32'h0;
      m_psc  = 0;
      for (int i = 0; i < NCH; i++) begin
         m_ch[i] = 32'h0; m_act_d[i] = 0; m_act_p[i] = 0; m_phase[i] = 0;
      end
      rq.delete();
   endtask

   task automatic model_step();
      bit          en, tick;
      int unsigned ps, idx;
      logic [31:0] msk;
      en   = m_ctrl[0];
      ps   = int'((m_ctrl >> 8) & 32'hFF);
      tick = en && (m_psc == ps);
      m_psc = en ? (m_psc + 1) % (ps + 1) : 0;
      for (int i = 0; i < NCH; i++) begin
         if (!en || m_act_p[i] == 0) begin
            m_act_d[i] = int'(m_ch[i] & DMASK);
            m_act_p[i] = int'((m_ch[i] >> 16) & DMASK);
            m_phase[i] = 0;
         end else if (tick) begin
            m_phase[i] = m_phase[i] + 1;
            if (m_phase[i] == m_act_p[i] + 1) begin
               m_phase[i] = 0;
               m_act_d[i] = int'(m_ch[i] & DMASK);
               m_act_p[i] = int'((m_ch[i] >> 16) & DMASK);
            end
         end
      end
      if (req && we) begin
         msk = bytemask(be);
         idx = int'(addr[9:2]);
         if (idx < NCH) begin
            m_ch[idx] = ((m_ch[idx] & ~msk) | (wdata & msk)) & FIELD_CH;
         end else if (idx == 128) begin
            m_ctrl = ((m_ctrl & ~msk) | (wdata & msk)) & FIELD_CTRL;
            if (be[1]) m_psc = 0;
         end
      end
   endtask

   // Reference model follows the DUT clock and asynchronous reset
   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_ni);
         if (!rst_ni) model_reset();
         else model_step();
      end
   end

   // Monitor: pops the scoreboard on every response and checks the waveform each cycle
   initial begin
      resp_t r;
      forever begin
         @(negedge clk);
         if (rst_ni) begin
            if (rvalid) begin
               checks++;
               if (rq.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_rvalid: got rvalid=1 expected no response (cycle %0d)", cyc);
               end else begin
                  r = rq.pop_front();
                  chk("rvalid_latency", 64'(cyc), 64'(r.issue + 1));
                  chk($sformatf("rdata@%0h", r.addr), 64'(rdata), 64'(r.exp));
               end
            end else begin
               chk("rdata_idle", 64'(rdata), 64'h0);
               if (rq.size() != 0 && rq[0].issue + 1 <= cyc) begin
                  r = rq.pop_front();
                  chk($sformatf("missing_rvalid@%0h", r.addr), 64'(rvalid), 64'h1);
               end
            end
            chk("pwm_o", 64'(pwm_o), 64'(model_pwm()));
         end
      end
   end

   task automatic bus_exp(input bit w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, input logic [31:0] e);
      resp_t r;
      r.issue = cyc; r.exp = e; r.addr = a;
      rq.push_back(r);
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   task automatic bus(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
      bus_exp(w, a, b, d, w ? 32'h0 : model_read(a));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_rise(input int ch, output bit ok);
      bit prev;
      prev = pwm_o[ch];
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (!prev && pwm_o[ch]) begin
            ok = 1'b1;
            break;
         end
         prev = pwm_o[ch];
      end
   endtask

   task automatic measure(input int ch, input int exp_hi, input int exp_lo, input string nm);
      bit ok;
      int hi, lo;
      wait_rise(ch, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_rise: got no rising edge expected one within 400 cycles", nm);
         return;
      end
      hi = 1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (pwm_o[ch]) hi++; else break;
      end
      lo = 1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (!pwm_o[ch]) lo++; else break;
      end
      chk({nm, "_high"}, 64'(hi), 64'(exp_hi));
      chk({nm, "_low"}, 64'(lo), 64'(exp_lo));
   endtask

   initial begin
      bit ok;
      logic [31:0] a, d;
      int unsigned idx;
      rst_ni = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_pwm", 64'(pwm_o), 64'h0);
      chk("reset_rvalid", 64'(rvalid), 64'h0);
      chk("reset_rdata", 64'(rdata), 64'h0);
      rst_ni = 1'b1;
      idle(1);

      // Basic waveform: period 4 duty 2 -> 2 high, 3 low
      bus(1'b1, 32'h200, 4'hF, 32'h0000_0001);
      bus(1'b1, 32'h000, 4'hF, 32'h0004_0002);
      measure(0, 2, 3, "basic");

      // Mid-cycle duty change takes effect at the next wrap
      idle(1);
      bus(1'b1, 32'h000, 4'b0001, 32'h0000_0004);
      measure(0, 4, 1, "duty_update");

      // Prescale 2 stretches every tick to 3 cycles
      bus(1'b1, 32'h200, 4'hF, 32'h0000_0201);
      bus(1'b1, 32'h000, 4'b0001, 32'h0000_0002);
      wait_rise(0, ok);
      measure(0, 6, 9, "prescale");

      // Byte-enable truncation and readback latency
      bus(1'b1, 32'h00C, 4'b0001, 32'hFFFF_FFFF);
      bus_exp(1'b0, 32'h00C, 4'hF, 32'h0, 32'h0000_00FF);
      bus_exp(1'b0, 32'h200, 4'hF, 32'h0, 32'h0000_0201);

      // Duty 0 -> always low, duty > period -> always high, disable -> all low
      bus(1'b1, 32'h200, 4'hF, 32'h0000_0001);
      bus(1'b1, 32'h004, 4'hF, 32'h0004_0000);
      bus(1'b1, 32'h008, 4'hF, 32'h0004_0005);
      idle(2);
      for (int n = 0; n < 20; n++) begin
         chk("duty0_low", 64'(pwm_o[1]), 64'h0);
         chk("duty_gt_period_high", 64'(pwm_o[2]), 64'h1);
         idle(1);
      end
      bus(1'b1, 32'h200, 4'hF, 32'h0000_0000);
      idle(1);
      for (int n = 0; n < 10; n++) begin
         chk("disabled_low", 64'(pwm_o), 64'h0);
         idle(1);
      end
      bus(1'b1, 32'h200, 4'hF, 32'h0000_0001);

      // Randomized traffic against the reference model
      for (int k = 0; k < 250; k++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
               idx = $urandom_range(0, NCH - 1);
               d = {8'($urandom()), 8'($urandom_range(0, 10)), 8'($urandom()), 8'($urandom_range(0, 12))};
               a = ($urandom() & 32'hFFFF_FC00) | (idx * 4);
               bus(1'b1, a, 4'($urandom()), d);
            end
            4, 5: begin
               idx = $urandom_range(0, NCH - 1);
               a = ($urandom() & 32'hFFFF_FC00) | (idx * 4);
               bus(1'b0, a, 4'hF, 32'h0);
            end
            6: begin
               d = {16'($urandom()), 8'($urandom_range(0, 3)), 7'($urandom()),
                    1'($urandom_range(0, 5) != 0)};
               bus(1'b1, ($urandom() & 32'hFFFF_FC00) | 32'h200, 4'($urandom()), d);
            end
            7: idle($urandom_range(1, 10));
            default: begin
               case ($urandom_range(0, 3))
                  0: a = 32'h204;
                  1: a = 32'h3FC;
                  2: a = 32'h100;
                  default: a = 32'($urandom_range(NCH, 15)) * 4;
               endcase
               a = a | ($urandom() & 32'hFFFF_FC00);
               bus(1'($urandom()), a, 4'($urandom()), $urandom());
            end
         endcase
      end

      // Reset mid-cycle with a request in flight
      bus(1'b1, 32'h200, 4'hF, 32'h0000_0001);
      bus(1'b1, 32'h008, 4'hF, 32'h0004_0005);
      idle(3);
      req = 1'b1; we = 1'b0; addr = 32'h008; be = 4'hF;
      #2;
      rst_ni = 1'b0;
      #1;
      chk("midreset_pwm", 64'(pwm_o), 64'h0);
      chk("midreset_rvalid", 64'(rvalid), 64'h0);
      chk("midreset_rdata", 64'(rdata), 64'h0);
      @(negedge clk);
      req = 1'b0;
      idle(2);
      rst_ni = 1'b1;
      idle(1);
      for (int i = 0; i < NCH; i++) bus_exp(1'b0, 32'(i * 4), 4'hF, 32'h0, 32'h0);
      bus_exp(1'b0, 32'h200, 4'hF, 32'h0, 32'h0);

      idle(5);
      checks++;
      if (rq.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d outstanding responses expected 0", rq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
